adc_frame_fifo: RTL and testbench

//  Multi-channel ADC sample buffer between the ADC driver and the localization
//  DSP. Stores one frame per wr_valid pulse (one sample from every hydrophone

---
 rtl/adc_frame_fifo_if.sv | 40 ++++
 rtl/adc_frame_fifo.sv | 169 ++++++++++++++++
 tb/tb_adc_frame_fifo.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_frame_fifo_if.sv
// Bundle of ADC frame FIFO control, write and read-stream signals.
// "master" is the producer/consumer side, "slave" is the FIFO itself.
interface adc_frame_fifo_if #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1024
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    // control
    logic                         flush;
    logic                         clr_ovf;
    // frame write side
    logic                         wr_valid;
    logic [NUM_CH*DATA_WIDTH-1:0] wr_data;
    // status
    logic                         full;
    logic                         almost_full;
    logic                         overflow;
    logic [LVL_W-1:0]             level;
    // channel-serial read stream
    logic                         rd_valid;
    logic                         rd_ready;
    logic [DATA_WIDTH-1:0]        rd_data;
    logic [CH_W-1:0]              rd_ch;
    logic                         rd_last;

    modport master (
        output flush, clr_ovf, wr_valid, wr_data, rd_ready,
        input  full, almost_full, overflow, level,
               rd_valid, rd_data, rd_ch, rd_last
    );

    modport slave (
        input  flush, clr_ovf, wr_valid, wr_data, rd_ready,
        output full, almost_full, overflow, level,
               rd_valid, rd_data, rd_ch, rd_last
    );
endinterface

// File: rtl/adc_frame_fifo.sv
// Multi-channel ADC frame buffer. Whole frames (one sample per channel) are
// written in one cycle; a one-frame output stage replays them as a
// channel-serial valid/ready stream. The output stage is not counted in level.
module adc_frame_fifo #(
    parameter int NUM_CH       = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int DEPTH        = 1024,
    parameter int AFULL_THRESH = DEPTH - 16
) (
    input  logic           clk,
    input  logic           rst,
    adc_frame_fifo_if.slave bus
);
    localparam int FRAME_W = NUM_CH * DATA_WIDTH;
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int CH_W    = $clog2(NUM_CH);
    localparam int LVL_W   = ADDR_W + 1;

    localparam logic [LVL_W-1:0] LVL_DEPTH = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AFULL = LVL_W'(AFULL_THRESH);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

    // Pick channel ch out of a packed frame (channel k lives at [k*DW +: DW]).
    function automatic logic [DATA_WIDTH-1:0] chan_sel(
        input logic [FRAME_W-1:0] frame,
        input logic [CH_W-1:0]    ch
    );
        logic [DATA_WIDTH-1:0] smp;
        smp = frame[int'(ch)*DATA_WIDTH +: DATA_WIDTH];
        return smp;
    endfunction

    // frame storage and pointers
    logic [FRAME_W-1:0]    mem_r [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_r;
    logic [ADDR_W-1:0]     rd_ptr_r;
    logic [LVL_W-1:0]      level_r;
    logic [LVL_W-1:0]      level_nxt_s;
    logic                  full_r;
    logic                  afull_r;
    logic                  ovf_r;

    // output stage
    logic [FRAME_W-1:0]    stage_r;
    logic                  valid_r;
    logic [CH_W-1:0]       ch_r;
    logic                  last_r;
    logic [DATA_WIDTH-1:0] data_r;

    // per-cycle decisions
    logic                  wr_acc_s;
    logic                  drop_s;
    logic                  xfer_s;
    logic                  stage_free_s;
    logic                  rd_issue_s;
    logic [CH_W-1:0]       ch_inc_s;
    logic [FRAME_W-1:0]    rd_frame_s;

    // Decide write accept/drop, stage reload and next fill level for this edge.
    always_comb begin
        wr_acc_s     = bus.wr_valid & ~full_r & ~bus.flush;
        drop_s       = bus.wr_valid &  full_r & ~bus.flush;
        xfer_s       = valid_r & bus.rd_ready;
        // the stage is reusable if empty or its final sample leaves on this edge
        stage_free_s = ~valid_r | (xfer_s & last_r);
        rd_issue_s   = (level_r != '0) & stage_free_s & ~bus.flush;
        ch_inc_s     = ch_r + CH_W'(1);
        rd_frame_s   = mem_r[rd_ptr_r];
        if (bus.flush) begin
            level_nxt_s = '0;
        end else if (wr_acc_s && !rd_issue_s) begin
            level_nxt_s = level_r + LVL_W'(1);
        end else if (!wr_acc_s && rd_issue_s) begin
            level_nxt_s = level_r - LVL_W'(1);
        end else begin
            level_nxt_s = level_r;
        end
    end

    // Frame RAM write port; the full check keeps it off the unread read slot.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= bus.wr_data;
        end
    end

    // Pointers, fill level and the level-derived status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            full_r   <= 1'b0;
            afull_r  <= 1'b0;
        end else begin
            level_r <= level_nxt_s;
            full_r  <= (level_nxt_s == LVL_DEPTH);
            afull_r <= (level_nxt_s >= LVL_AFULL);
            if (bus.flush) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
            end else begin
                if (wr_acc_s) begin
                    wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
                end
                if (rd_issue_s) begin
                    rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
                end
            end
        end
    end

    // Sticky overflow: a dropped frame beats a same-edge clear; flush leaves it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // Output stage: load a frame from RAM, then step through its channels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_r <= '0;
            valid_r <= 1'b0;
            ch_r    <= '0;
            last_r  <= 1'b0;
            data_r  <= '0;
        end else if (bus.flush) begin
            stage_r <= '0;
            valid_r <= 1'b0;
            ch_r    <= '0;
            last_r  <= 1'b0;
            data_r  <= '0;
        end else if (rd_issue_s) begin
            stage_r <= rd_frame_s;
            valid_r <= 1'b1;
            ch_r    <= '0;
            last_r  <= 1'b0;
            data_r  <= chan_sel(rd_frame_s, '0);
        end else if (xfer_s) begin
            if (last_r) begin
                valid_r <= 1'b0;
                last_r  <= 1'b0;
            end else begin
                ch_r   <= ch_inc_s;
                last_r <= (ch_inc_s == CH_LAST);
                data_r <= chan_sel(stage_r, ch_inc_s);
            end
        end else begin
            valid_r <= valid_r;
        end
    end

    assign bus.full        = full_r;
    assign bus.almost_full = afull_r;
    assign bus.overflow    = ovf_r;
    assign bus.level       = level_r;
    assign bus.rd_valid    = valid_r;
    assign bus.rd_data     = data_r;
    assign bus.rd_ch       = ch_r;
    assign bus.rd_last     = last_r;

endmodule

// File: tb/tb_adc_frame_fifo.sv
// Scoreboard bench for adc_frame_fifo: stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted sample.
module tb_adc_frame_fifo;
    localparam int NUM_CH = 4;
    localparam int DW     = 16;
    localparam int DEPTH  = 1024;
    localparam int AF     = 1008;

    typedef logic [DW+2:0] beat_t;   // {data, ch[1:0], last}

    logic  clk = 1'b0;
    logic  rst_n;
    int    n_cmp = 0;
    int    n_err = 0;
    beat_t sb[$];

    adc_frame_fifo_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus();

    adc_frame_fifo #(
        .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk_frame(input int idx);
        logic [63:0] f;
        f = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            f[k*DW +: DW] = 16'(idx*16 + k) ^ 16'h5A00;
        end
        return f;
    endfunction

    function automatic void push_frame(input logic [63:0] f);
        for (int k = 0; k < NUM_CH; k++) begin
            sb.push_back({f[k*DW +: DW], 2'(k), (k == NUM_CH-1)});
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_rd_valid"}, bus.rd_valid, 1'b0);
        check({tag, "_rd_data"},  bus.rd_data, 16'h0);
        check({tag, "_rd_ch"},    bus.rd_ch, 2'd0);
        check({tag, "_rd_last"},  bus.rd_last, 1'b0);
        check({tag, "_full"},     bus.full, 1'b0);
        check({tag, "_afull"},    bus.almost_full, 1'b0);
        check({tag, "_overflow"}, bus.overflow, 1'b0);
        check({tag, "_level"},    bus.level, 11'd0);
    endtask

    task automatic drain(input string tag, input int budget, output int cycles);
        bus.rd_ready = 1'b1;
        cycles = 0;
        while (sb.size() != 0 && cycles < budget) begin
            step();
            cycles++;
        end
        check({tag, "_drained"}, sb.size(), 0);
        bus.rd_ready = 1'b0;
    endtask

    // Monitor: compare every accepted beat; verify outputs hold while stalled.
    initial begin : monitor
        beat_t cur;
        beat_t prev;
        beat_t exp_b;
        logic  stall_prev;
        stall_prev = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {bus.rd_data, bus.rd_ch, bus.rd_last};
            if (stall_prev && bus.rd_valid) begin
                check("stall_hold", cur, prev);
            end
            if (bus.rd_valid && bus.rd_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got %0h expected no beat at %0t", cur, $time);
                end else begin
                    exp_b = sb.pop_front();
                    check("beat", cur, exp_b);
                end
            end
            stall_prev = bus.rd_valid & ~bus.rd_ready;
            prev = cur;
        end
    end

    // Absolute time bound so the run always ends.
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin : stim
        logic [63:0] f;
        logic [63:0] f0;
        int          cyc;

        rst_n        = 1'b0;
        bus.flush    = 1'b0;
        bus.clr_ovf  = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        step();
        step();
        chk_idle("reset");
        rst_n = 1'b1;
        step();

        // Single frame, latency and channel order.
        f = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        bus.wr_valid = 1'b1;
        bus.wr_data  = f;
        push_frame(f);
        step();
        bus.wr_valid = 1'b0;
        check("t2_valid_at_E", bus.rd_valid, 1'b0);
        check("t2_level_at_E", bus.level, 11'd1);
        bus.rd_ready = 1'b1;
        step();
        check("t2_valid_E1", bus.rd_valid, 1'b1);
        check("t2_data_E1", bus.rd_data, 16'h0001);
        check("t2_ch_E1", bus.rd_ch, 2'd0);
        check("t2_level_E1", bus.level, 11'd0);
        repeat (4) step();
        check("t2_valid_after", bus.rd_valid, 1'b0);
        check("t2_sb_empty", sb.size(), 0);
        bus.rd_ready = 1'b0;

        // Fill to full plus one dropped frame.
        f0 = mk_frame(101);
        for (int n = 1; n <= DEPTH+2; n++) begin
            f = mk_frame(100 + n);
            bus.wr_valid = 1'b1;
            bus.wr_data  = f;
            if (n <= DEPTH+1) push_frame(f);
            step();
            if (n >= 2 && n <= DEPTH+1) begin
                check("t3_level", bus.level, 64'(n-1));
                check("t3_afull", bus.almost_full, ((n-1) >= AF));
            end
            if (n == DEPTH) check("t3_not_full", bus.full, 1'b0);
            if (n == DEPTH+1) begin
                check("t3_full", bus.full, 1'b1);
                check("t3_ovf_pre", bus.overflow, 1'b0);
            end
        end
        bus.wr_valid = 1'b0;
        check("t3_ovf", bus.overflow, 1'b1);
        check("t3_level_full", bus.level, 11'd1024);
        check("t3_full_hold", bus.full, 1'b1);
        check("t3_stage_ch0", bus.rd_data, f0[15:0]);
        drain("t3", 6000, cyc);
        check("t3_no_bubble", cyc, 64'(4100));
        check("t3_valid_end", bus.rd_valid, 1'b0);
        check("t3_level_end", bus.level, 11'd0);
        check("t3_afull_end", bus.almost_full, 1'b0);
        check("t3_ovf_kept", bus.overflow, 1'b1);

        // Continuous writes every 4 cycles against a random consumer.
        for (int c = 0; c < 640; c++) begin
            bus.wr_valid = ((c % 4) == 0);
            if ((c % 4) == 0) begin
                f = mk_frame(2000 + c/4);
                bus.wr_data = f;
                push_frame(f);
            end
            bus.rd_ready = ($urandom_range(0, 3) != 0);
            step();
            check("t4_level_le_depth", (bus.level <= 11'd1024), 1'b1);
        end
        bus.wr_valid = 1'b0;
        drain("t4", 5000, cyc);
        step();
        check("t4_valid_end", bus.rd_valid, 1'b0);
        check("t4_level_end", bus.level, 11'd0);

        // Flush mid-frame with a same-edge write.
        f = mk_frame(5000);
        bus.wr_valid = 1'b1;
        bus.wr_data  = f;
        push_frame(f);
        step();
        f = mk_frame(5001);
        bus.wr_data = f;
        push_frame(f);
        step();
        bus.wr_valid = 1'b0;
        step();
        bus.rd_ready = 1'b1;
        step();
        step();
        bus.rd_ready = 1'b0;
        bus.flush    = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = mk_frame(6000);
        step();
        bus.flush    = 1'b0;
        bus.wr_valid = 1'b0;
        check("t5_consumed", sb.size(), 6);
        check("t5_valid", bus.rd_valid, 1'b0);
        check("t5_level", bus.level, 11'd0);
        check("t5_ovf_kept", bus.overflow, 1'b1);
        check("t5_full", bus.full, 1'b0);
        sb.delete();
        step();
        check("t5_still_empty", bus.rd_valid, 1'b0);
        f = mk_frame(6100);
        bus.wr_valid = 1'b1;
        bus.wr_data  = f;
        push_frame(f);
        step();
        bus.wr_valid = 1'b0;
        drain("t5", 50, cyc);
        step();
        check("t5_valid_end", bus.rd_valid, 1'b0);

        // Overflow clear against a same-edge drop.
        bus.clr_ovf = 1'b1;
        step();
        bus.clr_ovf = 1'b0;
        check("t6_clr", bus.overflow, 1'b0);
        for (int n = 1; n <= DEPTH+1; n++) begin
            f = mk_frame(3000 + n);
            bus.wr_valid = 1'b1;
            bus.wr_data  = f;
            push_frame(f);
            step();
        end
        check("t6_full", bus.full, 1'b1);
        check("t6_level", bus.level, 11'd1024);
        check("t6_ovf_pre", bus.overflow, 1'b0);
        bus.wr_data = mk_frame(9999);
        bus.clr_ovf = 1'b1;
        step();
        check("t6_drop_wins", bus.overflow, 1'b1);
        check("t6_level_drop", bus.level, 11'd1024);
        bus.wr_valid = 1'b0;
        step();
        bus.clr_ovf = 1'b0;
        check("t6_clr_alone", bus.overflow, 1'b0);
        bus.wr_valid = 1'b1;
        step();
        bus.wr_valid = 1'b0;
        check("t6_drop_again", bus.overflow, 1'b1);

        // Asynchronous reset while streaming.
        bus.rd_ready = 1'b1;
        repeat (6) step();
        check("t1_streaming", bus.rd_valid, 1'b1);
        check("t1_level_pre", bus.level, 11'd1023);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("t1_async");
        sb.delete();
        bus.rd_ready = 1'b0;
        rst_n = 1'b1;
        step();
        chk_idle("t1_post");
        f = mk_frame(7777);
        bus.wr_valid = 1'b1;
        bus.wr_data  = f;
        push_frame(f);
        step();
        bus.wr_valid = 1'b0;
        drain("t1", 50, cyc);
        step();
        check("t1_valid_end", bus.rd_valid, 1'b0);
        check("t1_level_end", bus.level, 11'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
